// File: rtl/vga_timing_pkg.sv
// Shared timing constants, axis record and sizing helpers for the video timing generator.
package vga_timing_pkg;

  localparam int unsigned DEF_H_DISPLAY = 800;
  localparam int unsigned DEF_H_FRONT   = 56;
  localparam int unsigned DEF_H_SYNC    = 120;
  localparam int unsigned DEF_H_BACK    = 64;
  localparam int unsigned DEF_V_DISPLAY = 600;
  localparam int unsigned DEF_V_FRONT   = 37;
  localparam int unsigned DEF_V_SYNC    = 6;
  localparam int unsigned DEF_V_BACK    = 23;

  typedef struct packed {
    int unsigned display;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
  } axis_t;

  function automatic int unsigned total(input axis_t a);
    return a.display + a.front + a.sync + a.back;
  endfunction

  // Bits needed to hold counts 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: wrapping position counter plus sync-window and active-region decode.
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int unsigned DISPLAY = 8,
  parameter int unsigned FRONT   = 2,
  parameter int unsigned SYNC    = 3,
  parameter int unsigned BACK    = 1,
  parameter int unsigned W       = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o,
  output logic         sync_o,
  output logic         active_o
);

  localparam int unsigned TOTAL = total(axis_t'{DISPLAY, FRONT, SYNC, BACK});

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap_o = inc_i && (cnt_q == W'(TOTAL - 1));

  // Clear wins over increment so a restart lands exactly on zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wrap_o) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign sync_o   = (cnt_q >= W'(DISPLAY + FRONT)) && (cnt_q < W'(DISPLAY + FRONT + SYNC));
  assign active_o = (cnt_q < W'(DISPLAY));

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator driven by a pixel enable.
// Define VGA_TIMING_PREFETCH_EN to add the LEAD-deep output delay and early fetch port.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter bit          HS_POL    = 1'b1,
  parameter bit          VS_POL    = 1'b1,
  parameter int unsigned X_W       = 11,
  parameter int unsigned Y_W       = 10
`ifdef VGA_TIMING_PREFETCH_EN
  , parameter int unsigned LEAD    = 4
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pix_en,
  input  logic           restart,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic           vblank,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           line_start,
  output logic           frame_start
`ifdef VGA_TIMING_PREFETCH_EN
  , output logic           fetch_valid,
  output logic [X_W-1:0] fetch_x,
  output logic [Y_W-1:0] fetch_y
`endif
);

  localparam int unsigned H_TOTAL = total(axis_t'{H_DISPLAY, H_FRONT, H_SYNC, H_BACK});
  localparam int unsigned V_TOTAL = total(axis_t'{V_DISPLAY, V_FRONT, V_SYNC, V_BACK});

  if (H_DISPLAY == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_DISPLAY == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_zero_chk
    $fatal(1, "vga_timing_gen: timing fields must be non-zero");
  end
  if (X_W < cnt_width(H_TOTAL) || Y_W < cnt_width(V_TOTAL)) begin : g_width_chk
    $fatal(1, "vga_timing_gen: X_W/Y_W too narrow for the totals");
  end

`ifdef VGA_TIMING_PREFETCH_EN
  if (LEAD < 1) begin : g_lead_chk
    $fatal(1, "vga_timing_gen: LEAD must be at least 1");
  end
  localparam int DEPTH = LEAD + 1;
`else
  localparam int DEPTH = 1;
`endif

  // Packed output word: {hsync, vsync, de, vblank, line_start, frame_start, x, y}.
  localparam int OW     = X_W + Y_W + 6;
  localparam int FS_B   = X_W + Y_W;
  localparam int LS_B   = FS_B + 1;
  localparam int VB_B   = FS_B + 2;
  localparam int DE_B   = FS_B + 3;
  localparam int VS_B   = FS_B + 4;
  localparam int HS_B   = FS_B + 5;
  localparam logic [OW-1:0] RST_VEC = {~HS_POL, ~VS_POL, 4'b0000, {(X_W + Y_W){1'b0}}};

  logic [X_W-1:0] h_cnt;
  logic [Y_W-1:0] v_cnt;
  logic           h_wrap, h_sync_act, h_act;
  logic           v_sync_act, v_act, v_wrap_unused;

  vga_axis_timer #(
    .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(X_W)
  ) u_h_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (pix_en),
    .clr_i   (restart),
    .cnt_o   (h_cnt),
    .wrap_o  (h_wrap),
    .sync_o  (h_sync_act),
    .active_o(h_act)
  );

  vga_axis_timer #(
    .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(Y_W)
  ) u_v_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (h_wrap),
    .clr_i   (restart),
    .cnt_o   (v_cnt),
    .wrap_o  (v_wrap_unused),
    .sync_o  (v_sync_act),
    .active_o(v_act)
  );

  logic [OW-1:0] dec;

  assign dec = {h_sync_act ? HS_POL : ~HS_POL,
                v_sync_act ? VS_POL : ~VS_POL,
                h_act && v_act,
                ~v_act,
                h_cnt == '0,
                (h_cnt == '0) && (v_cnt == '0),
                h_cnt,
                v_cnt};

  // Stage 0 holds the fresh decode; later stages (prefetch builds only) delay it.
  logic [DEPTH-1:0][OW-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d = pipe_q;
    if (restart) begin
      pipe_d = {DEPTH{RST_VEC}};
    end else if (pix_en) begin
      pipe_d[0] = dec;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= {DEPTH{RST_VEC}};
    end else begin
      pipe_q <= pipe_d;
    end
  end

  logic [OW-1:0] out_w;
  assign out_w = pipe_q[DEPTH-1];

  assign y           = out_w[Y_W-1:0];
  assign x           = out_w[Y_W +: X_W];
  assign frame_start = out_w[FS_B];
  assign line_start  = out_w[LS_B];
  assign vblank      = out_w[VB_B];
  assign de          = out_w[DE_B];
  assign vsync       = out_w[VS_B];
  assign hsync       = out_w[HS_B];

`ifdef VGA_TIMING_PREFETCH_EN
  assign fetch_valid = pipe_q[0][DE_B];
  assign fetch_x     = pipe_q[0][Y_W +: X_W];
  assign fetch_y     = pipe_q[0][Y_W-1:0];
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a 14x8 raster with active-low syncs.
module tb_vga_timing_gen;

  localparam int X_W = 4;
  localparam int Y_W = 3;
  localparam int OW  = X_W + Y_W + 6;
`ifdef VGA_TIMING_PREFETCH_EN
  localparam int LD = 4;
`else
  localparam int LD = 0;
`endif
  // {hsync, vsync, de, vblank, line_start, frame_start, x, y}
  localparam logic [OW-1:0] RSTV = 13'b1_1_0_0_0_0_0000_000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  logic restart = 1'b0;
  logic hsync, vsync, de, vblank, line_start, frame_start;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic fetch_valid;
  logic [X_W-1:0] fetch_x;
  logic [Y_W-1:0] fetch_y;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .X_W(X_W), .Y_W(Y_W)
`ifdef VGA_TIMING_PREFETCH_EN
    , .LEAD(LD)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .restart    (restart),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .vblank     (vblank),
    .x          (x),
    .y          (y),
    .line_start (line_start),
    .frame_start(frame_start)
`ifdef VGA_TIMING_PREFETCH_EN
    , .fetch_valid(fetch_valid),
    .fetch_x    (fetch_x),
    .fetch_y    (fetch_y)
`endif
  );

`ifndef VGA_TIMING_PREFETCH_EN
  assign fetch_valid = 1'b0;
  assign fetch_x     = '0;
  assign fetch_y     = '0;
`endif

  logic [OW-1:0] obs_main;
  logic [7:0]    obs_fetch;
  assign obs_main  = {hsync, vsync, de, vblank, line_start, frame_start, x, y};
  assign obs_fetch = {fetch_valid, fetch_x, fetch_y};

  typedef struct packed {
    logic [OW-1:0] m;
    logic [7:0]    f;
  } exp_t;

  exp_t          sb[$];
  logic [OW-1:0] hist[$];
  logic [OW-1:0] exp_main;
  logic [7:0]    exp_fetch;
  int            mh, mv;
  int            nvec = 0;
  int            nerr = 0;

  function automatic logic [OW-1:0] decode(input int h, input int v);
    logic hs, vs, dv, vb, ls, fs;
    hs = !(h >= 10 && h < 13);
    vs = !(v >= 5 && v < 7);
    dv = (h < 8) && (v < 4);
    vb = (v >= 4);
    ls = (h == 0);
    fs = (h == 0) && (v == 0);
    return {hs, vs, dv, vb, ls, fs, 4'(h), 3'(v)};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    mh = 0;
    mv = 0;
    hist.delete();
    exp_main  = RSTV;
    exp_fetch = 8'h00;
  endtask

  // One clock: drive inputs, push the expected post-edge outputs, then compare.
  task automatic step(input logic en, input logic rs);
    exp_t e;
    logic [OW-1:0] d;
    pix_en  = en;
    restart = rs;
    if (rs) begin
      model_clear();
    end else if (en) begin
      d = decode(mh, mv);
      hist.push_back(d);
      if (hist.size() > LD + 1) void'(hist.pop_front());
      exp_fetch = {d[10], d[6:0]};
      exp_main  = (hist.size() > LD) ? hist[hist.size() - 1 - LD] : RSTV;
      mh++;
      if (mh == 14) begin
        mh = 0;
        mv = (mv + 1) % 8;
      end
    end
    sb.push_back('{m: exp_main, f: exp_fetch});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("out", 16'(obs_main), 16'(e.m));
`ifdef VGA_TIMING_PREFETCH_EN
    check("fetch", 16'(obs_fetch), 16'(e.f));
`endif
  endtask

  int  fs_cnt, ls_cnt, de_cnt, hs_cnt, vs_cnt, vb_cnt;
  bit  found;

  initial begin
    // Reset state
    model_clear();
    #12;
    check("reset_out", 16'(obs_main), 16'(RSTV));
    check("reset_fetch", 16'(obs_fetch), 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Continuous enables across a full frame plus one pixel
    fs_cnt = 0; ls_cnt = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; vb_cnt = 0;
    for (int i = 0; i < 113 + LD; i++) begin
      step(1'b1, 1'b0);
      fs_cnt += int'(frame_start);
      ls_cnt += int'(line_start);
      if (i >= LD && i < LD + 112) begin
        de_cnt += int'(de);
        hs_cnt += int'(!hsync);
        vs_cnt += int'(!vsync);
        vb_cnt += int'(vblank);
      end
    end
    check("frame_start_count", 16'(fs_cnt), 16'd2);
    check("line_start_count", 16'(ls_cnt), 16'd9);
    check("de_per_frame", 16'(de_cnt), 16'd32);
    check("hsync_low_per_frame", 16'(hs_cnt), 16'd24);
    check("vsync_low_per_frame", 16'(vs_cnt), 16'd28);
    check("vblank_per_frame", 16'(vb_cnt), 16'd56);

    // Enable every third cycle: values and strobes hold between enables
    for (int k = 0; k < 90; k++) step(k % 3 == 0, 1'b0);

    // Restart together with pix_en while showing (9,2)
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      step(1'b1, 1'b0);
      found = (x == 4'd9) && (y == 3'd2);
    end
    check("find_x9_y2", 16'(found), 16'd1);
    step(1'b1, 1'b1);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0);

    // Restart without pix_en still clears
    step(1'b0, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0);

    // Asynchronous reset mid-line at x=5
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      step(1'b1, 1'b0);
      found = (x == 4'd5);
    end
    check("find_x5", 16'(found), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", 16'(obs_main), 16'(RSTV));
    check("async_reset_fetch", 16'(obs_fetch), 16'h0000);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) step(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
